// File: rtl/i2c_txn_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_txn_sequencer_if
//
// Bundles the three handshakes of the I2C transaction sequencer:
//   cmd_*  : host -> sequencer command stream (valid/ready)
//   rsp_*  : sequencer -> host response stream (valid/ready)
//   m_*    : sequencer <-> I2C master start/ready handshake
//
// Modports:
//   slave  : the sequencer's view (accepts commands, produces responses,
//            drives the master request lines)
//   master : the environment's view (host plus I2C master model)
// ---------------------------------------------------------------------------
interface i2c_txn_sequencer_if;

   // Command stream
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [6:0] cmd_address;
   logic [7:0] cmd_data;

   // Response stream
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_write;
   logic [6:0] rsp_address;
   logic [7:0] rsp_data;
   logic       rsp_error;
   logic       rsp_timeout;

   // I2C master handshake
   logic       m_start;
   logic       m_write;
   logic [6:0] m_address;
   logic [7:0] m_write_data;
   logic       m_ready;
   logic       m_error;
   logic [7:0] m_read_data;

   modport slave (
      input  cmd_valid, cmd_write, cmd_address, cmd_data,
      output cmd_ready,
      output rsp_valid, rsp_write, rsp_address, rsp_data, rsp_error, rsp_timeout,
      input  rsp_ready,
      output m_start, m_write, m_address, m_write_data,
      input  m_ready, m_error, m_read_data
   );

   modport master (
      output cmd_valid, cmd_write, cmd_address, cmd_data,
      input  cmd_ready,
      input  rsp_valid, rsp_write, rsp_address, rsp_data, rsp_error, rsp_timeout,
      output rsp_ready,
      input  m_start, m_write, m_address, m_write_data,
      output m_ready, m_error, m_read_data
   );

endinterface

// File: rtl/i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_txn_sequencer
//
// Queues single-byte I2C read/write commands, issues them one at a time to
// an I2C master over a start/ready handshake, and captures each outcome
// (read data or echoed write data, no-ack error, timeout) into a response
// FIFO.
//
// Parameters:
//   CMD_DEPTH : command FIFO entries (power of 2, >= 2)
//   RSP_DEPTH : response FIFO entries (power of 2, >= 2)
//   TIMEOUT   : cycles allowed in the wait states before a transaction is
//               abandoned (8-bit timer)
//
// Ports:
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus       : command, response and master handshakes (slave modport)
//   busy      : FSM is not idle
//   cmd_count : command FIFO occupancy
// ---------------------------------------------------------------------------
module i2c_txn_sequencer #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                         clock,
   input  logic                         reset_n,
   i2c_txn_sequencer_if.slave           bus,
   output logic                         busy,
   output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);

   localparam logic [CAW:0] CMD_FULL_C = (CAW+1)'(CMD_DEPTH);
   localparam logic [RAW:0] RSP_FULL_C = (RAW+1)'(RSP_DEPTH);
   localparam logic [CAW:0] CMD_ONE_C  = (CAW+1)'(1);
   localparam logic [RAW:0] RSP_ONE_C  = (RAW+1)'(1);
   localparam logic [7:0]   TIMEOUT_C  = 8'(TIMEOUT);

   typedef struct packed {
      logic       write;
      logic [6:0] address;
      logic [7:0] data;
   } cmd_entry_t;

   typedef struct packed {
      logic       write;
      logic [6:0] address;
      logic [7:0] data;
      logic       error;
      logic       timeout;
   } rsp_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_POST
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   cmd_entry_t   cmd_mem_q [CMD_DEPTH];
   logic [CAW:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
   logic [CAW:0] cmd_occ;
   logic         cmd_full, cmd_empty;
   logic         cmd_push, cmd_pop;
   cmd_entry_t   cmd_head;

   // Pointers carry one extra wrap bit so occupancy is a plain difference.
   assign cmd_occ       = cmd_wr_ptr_q - cmd_rd_ptr_q;
   assign cmd_full      = (cmd_occ == CMD_FULL_C);
   assign cmd_empty     = (cmd_occ == '0);
   assign cmd_push      = bus.cmd_valid & ~cmd_full;
   assign cmd_head      = cmd_mem_q[cmd_rd_ptr_q[CAW-1:0]];
   assign bus.cmd_ready = ~cmd_full;
   assign cmd_count     = cmd_occ;

   // NOTE: storage arrays carry no reset; validity is tracked by the
   // pointers, and leaving the array out of reset keeps it a plain RAM.
   always_ff @(posedge clock) begin
      if (cmd_push) begin
         cmd_mem_q[cmd_wr_ptr_q[CAW-1:0]] <= '{write:   bus.cmd_write,
                                              address: bus.cmd_address,
                                              data:    bus.cmd_data};
      end
   end

   // NOTE: every clocked block uses non-blocking assignments so all
   // registers sample the same pre-edge values regardless of block order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmd_wr_ptr_q <= '0;
         cmd_rd_ptr_q <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + CMD_ONE_C;
         if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + CMD_ONE_C;
      end
   end

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   rsp_entry_t   rsp_mem_q [RSP_DEPTH];
   logic [RAW:0] rsp_wr_ptr_q, rsp_rd_ptr_q;
   logic [RAW:0] rsp_occ;
   logic         rsp_full, rsp_empty;
   logic         rsp_push, rsp_pop;
   rsp_entry_t   rsp_head;
   rsp_entry_t   rsp_new;

   assign rsp_occ   = rsp_wr_ptr_q - rsp_rd_ptr_q;
   assign rsp_full  = (rsp_occ == RSP_FULL_C);
   assign rsp_empty = (rsp_occ == '0);
   assign rsp_pop   = ~rsp_empty & bus.rsp_ready;

   // An empty FIFO presents all zeros rather than stale storage.
   assign rsp_head  = rsp_empty ? '0 : rsp_mem_q[rsp_rd_ptr_q[RAW-1:0]];

   assign bus.rsp_valid   = ~rsp_empty;
   assign bus.rsp_write   = rsp_head.write;
   assign bus.rsp_address = rsp_head.address;
   assign bus.rsp_data    = rsp_head.data;
   assign bus.rsp_error   = rsp_head.error;
   assign bus.rsp_timeout = rsp_head.timeout;

   always_ff @(posedge clock) begin
      if (rsp_push) rsp_mem_q[rsp_wr_ptr_q[RAW-1:0]] <= rsp_new;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_wr_ptr_q <= '0;
         rsp_rd_ptr_q <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + RSP_ONE_C;
         if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + RSP_ONE_C;
      end
   end

   // ------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------
   state_t     state_q, state_d;
   logic       m_start_q, m_start_d;
   logic       m_write_q, m_write_d;
   logic [6:0] m_address_q, m_address_d;
   logic [7:0] m_write_data_q, m_write_data_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] cap_data_q, cap_data_d;
   logic       cap_error_q, cap_error_d;
   logic       cap_timeout_q, cap_timeout_d;

   assign bus.m_start      = m_start_q;
   assign bus.m_write      = m_write_q;
   assign bus.m_address    = m_address_q;
   assign bus.m_write_data = m_write_data_q;
   assign busy             = (state_q != S_IDLE);

   // The request registers still hold the issued command during POST.
   assign rsp_new = '{write:   m_write_q,
                      address: m_address_q,
                      data:    cap_data_q,
                      error:   cap_error_q,
                      timeout: cap_timeout_q};

   // NOTE: every signal driven here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      m_start_d      = 1'b0;
      m_write_d      = m_write_q;
      m_address_d    = m_address_q;
      m_write_data_d = m_write_data_q;
      timer_d        = timer_q;
      cap_data_d     = cap_data_q;
      cap_error_d    = cap_error_q;
      cap_timeout_d  = cap_timeout_q;
      cmd_pop        = 1'b0;
      rsp_push       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // The issue work (load, pop, timer clear, start pulse) is done
            // on the edge entering ISSUE, so m_start and the reduced
            // cmd_count are both visible during the ISSUE cycle itself.
            if (!cmd_empty && !rsp_full && bus.m_ready) begin
               state_d        = S_ISSUE;
               cmd_pop        = 1'b1;
               m_write_d      = cmd_head.write;
               m_address_d    = cmd_head.address;
               m_write_data_d = cmd_head.data;
               m_start_d      = 1'b1;
               timer_d        = '0;
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end

         S_WAIT_BUSY, S_WAIT_DONE: begin
            timer_d = timer_q + 8'd1;
            // Timeout is tested first so it wins over a same-cycle m_ready.
            if (timer_q == TIMEOUT_C) begin
               state_d       = S_POST;
               cap_data_d    = 8'h00;
               cap_error_d   = 1'b1;
               cap_timeout_d = 1'b1;
            end else if (state_q == S_WAIT_BUSY) begin
               if (!bus.m_ready) state_d = S_WAIT_DONE;
            end else if (bus.m_ready) begin
               state_d       = S_POST;
               cap_data_d    = m_write_q ? m_write_data_q : bus.m_read_data;
               cap_error_d   = bus.m_error;
               cap_timeout_d = 1'b0;
            end
         end

         S_POST: begin
            // Issue was gated on !rsp_full, so there is always room here.
            rsp_push = 1'b1;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         m_start_q      <= 1'b0;
         m_write_q      <= 1'b0;
         m_address_q    <= '0;
         m_write_data_q <= '0;
         timer_q        <= '0;
         cap_data_q     <= '0;
         cap_error_q    <= 1'b0;
         cap_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         m_start_q      <= m_start_d;
         m_write_q      <= m_write_d;
         m_address_q    <= m_address_d;
         m_write_data_q <= m_write_data_d;
         timer_q        <= timer_d;
         cap_data_q     <= cap_data_d;
         cap_error_q    <= cap_error_d;
         cap_timeout_q  <= cap_timeout_d;
      end
   end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_sequencer
//
// Directed bench for i2c_txn_sequencer. A behavioural I2C master model
// answers start pulses: slaves 0x50-0x53 acknowledge (0x53 initially holds
// 0xA5), every other address NAKs. The model can be told to hang (never
// drop m_ready), to look busy while idle, or to stretch a transaction.
// ---------------------------------------------------------------------------
module tb_i2c_txn_sequencer;

   localparam int TIMEOUT = 255;

   logic       clock;
   logic       reset_n;
   logic       busy;
   logic [2:0] cmd_count;

   i2c_txn_sequencer_if bus ();

   i2c_txn_sequencer #(
      .CMD_DEPTH (4),
      .RSP_DEPTH (4),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .busy      (busy),
      .cmd_count (cmd_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // I2C master model
   // ------------------------------------------------------------------
   logic       hang      = 1'b0;
   logic       hold_busy = 1'b0;
   int         busy_len  = 3;
   int         start_cnt = 0;
   logic       mock_write;
   logic [6:0] mock_addr;
   logic [7:0] mock_wdata;
   logic [7:0] slave_mem [4];

   initial begin
      slave_mem[0] = 8'h00;
      slave_mem[1] = 8'h00;
      slave_mem[2] = 8'h00;
      slave_mem[3] = 8'hA5;
      mock_write      = 1'b0;
      mock_addr       = '0;
      mock_wdata      = '0;
      bus.m_ready     = 1'b1;
      bus.m_error     = 1'b0;
      bus.m_read_data = 8'h00;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            bus.m_ready     = 1'b1;
            bus.m_error     = 1'b0;
            bus.m_read_data = 8'h00;
         end else if (bus.m_start) begin
            start_cnt++;
            mock_write = bus.m_write;
            mock_addr  = bus.m_address;
            mock_wdata = bus.m_write_data;
            if (!hang) begin
               bus.m_ready = 1'b0;
               for (int i = 0; i < busy_len; i++) begin
                  @(negedge clock);
                  if (!reset_n) break;
               end
               if (!reset_n) begin
                  bus.m_error     = 1'b0;
                  bus.m_read_data = 8'h00;
               end else begin
                  bus.m_error = (mock_addr[6:2] != 5'b10100);
                  if (mock_write) begin
                     if (!bus.m_error) slave_mem[mock_addr[1:0]] = mock_wdata;
                  end else begin
                     bus.m_read_data = bus.m_error ? 8'hFF : slave_mem[mock_addr[1:0]];
                  end
               end
               bus.m_ready = 1'b1;
            end
         end else begin
            bus.m_ready = ~hold_busy;
         end
      end
   end

   // ------------------------------------------------------------------
   // Host-side helpers (all return on a negative edge)
   // ------------------------------------------------------------------
   task automatic push_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
      bit done = 0;
      @(negedge clock);
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = w;
      bus.cmd_address = a;
      bus.cmd_data    = d;
      for (int i = 0; i < 100 && !done; i++) begin
         if (bus.cmd_ready) done = 1;
         @(negedge clock);
      end
      bus.cmd_valid = 1'b0;
      if (!done) check("push_accept", 0, 1);
   endtask

   task automatic get_rsp(input string tag, input logic w, input logic [6:0] a,
                          input logic [7:0] d, input logic e, input logic t);
      for (int i = 0; i < 600 && !bus.rsp_valid; i++) @(negedge clock);
      check({tag, "_valid"}, bus.rsp_valid, 1);
      if (bus.rsp_valid) begin
         check({tag, "_write"},   bus.rsp_write,   w);
         check({tag, "_address"}, bus.rsp_address, a);
         check({tag, "_data"},    bus.rsp_data,    d);
         check({tag, "_error"},   bus.rsp_error,   e);
         check({tag, "_timeout"}, bus.rsp_timeout, t);
         bus.rsp_ready = 1'b1;
         @(negedge clock);
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic wait_start(output int t0);
      t0 = -1;
      for (int i = 0; i < 100 && t0 < 0; i++) begin
         @(negedge clock);
         if (bus.m_start) t0 = cyc;
      end
      check("start_seen", (t0 >= 0), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int t0;
      int s0;

      reset_n         = 1'b0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_write   = 1'b0;
      bus.cmd_address = '0;
      bus.cmd_data    = '0;
      bus.rsp_ready   = 1'b0;

      // Reset values
      repeat (2) @(negedge clock);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_m_start",   bus.m_start,   0);
      check("rst_busy",      busy,          0);
      check("rst_cmd_count", cmd_count,     0);
      check("rst_rsp_bits",  {bus.rsp_write, bus.rsp_address, bus.rsp_data,
                              bus.rsp_error, bus.rsp_timeout}, 0);
      check("rst_m_regs",    {bus.m_write, bus.m_address, bus.m_write_data}, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Write 0x21 to 0x50: push in cycle N, start in N+2 only
      push_cmd(1'b1, 7'h50, 8'h21);
      check("w1_count_n1", cmd_count,   1);
      check("w1_start_n1", bus.m_start, 0);
      @(negedge clock);
      check("w1_start_n2", bus.m_start, 1);
      check("w1_count_n2", cmd_count,   0);
      check("w1_m_addr",   bus.m_address,    7'h50);
      check("w1_m_wdata",  bus.m_write_data, 8'h21);
      check("w1_m_write",  bus.m_write,      1);
      @(negedge clock);
      check("w1_start_n3", bus.m_start, 0);
      get_rsp("w1", 1'b1, 7'h50, 8'h21, 1'b0, 1'b0);
      check("w1_m_addr_held", bus.m_address, 7'h50);
      check("w1_starts",      start_cnt,     1);
      check("empty_head_zero", {bus.rsp_write, bus.rsp_address, bus.rsp_data}, 0);

      // Read from 0x53
      push_cmd(1'b0, 7'h53, 8'h00);
      get_rsp("rd53", 1'b0, 7'h53, 8'hA5, 1'b0, 1'b0);

      // Write to unpopulated 0x10 -> NAK, data echoed
      push_cmd(1'b1, 7'h10, 8'h77);
      get_rsp("nak10", 1'b1, 7'h10, 8'h77, 1'b1, 1'b0);

      // Timeout: master never drops m_ready
      hang = 1'b1;
      s0 = start_cnt;
      push_cmd(1'b1, 7'h50, 8'h99);
      wait_start(t0);
      for (int i = 0; i < 400 && !bus.rsp_valid; i++) @(negedge clock);
      // POST sits TIMEOUT+2 cycles after the start pulse; rsp_valid one later.
      check("to_latency", cyc - t0, TIMEOUT + 3);
      get_rsp("to", 1'b1, 7'h50, 8'h00, 1'b1, 1'b1);
      check("to_single_start", start_cnt - s0, 1);
      hang = 1'b0;
      repeat (2) @(negedge clock);

      // Backpressure: master looks busy while 4 commands queue up
      hold_busy = 1'b1;
      repeat (2) @(negedge clock);
      s0 = start_cnt;
      push_cmd(1'b1, 7'h50, 8'h11);
      push_cmd(1'b1, 7'h51, 8'h22);
      push_cmd(1'b1, 7'h52, 8'h33);
      push_cmd(1'b1, 7'h53, 8'h44);
      check("bp_cmd_ready_low", bus.cmd_ready, 0);
      check("bp_count_full",    cmd_count,     4);
      hold_busy = 1'b0;
      push_cmd(1'b1, 7'h52, 8'h55);
      repeat (80) @(negedge clock);
      check("bp_four_starts", start_cnt - s0, 4);
      check("bp_busy_idle",   busy,           0);
      check("bp_rsp_valid",   bus.rsp_valid,  1);
      check("bp_fifth_queued", cmd_count,     1);
      get_rsp("bp0", 1'b1, 7'h50, 8'h11, 1'b0, 1'b0);
      get_rsp("bp1", 1'b1, 7'h51, 8'h22, 1'b0, 1'b0);
      get_rsp("bp2", 1'b1, 7'h52, 8'h33, 1'b0, 1'b0);
      get_rsp("bp3", 1'b1, 7'h53, 8'h44, 1'b0, 1'b0);
      get_rsp("bp4", 1'b1, 7'h52, 8'h55, 1'b0, 1'b0);
      check("bp_total_starts", start_cnt - s0, 5);
      check("bp_drained", bus.rsp_valid, 0);

      // Reset during WAIT_DONE with 2 commands queued
      busy_len = 30;
      s0 = start_cnt;
      push_cmd(1'b1, 7'h50, 8'hA1);
      push_cmd(1'b1, 7'h51, 8'hA2);
      push_cmd(1'b1, 7'h52, 8'hA3);
      @(negedge clock);
      check("rr_in_flight", start_cnt - s0, 1);
      check("rr_busy",      busy,           1);
      check("rr_queued",    cmd_count,      2);
      reset_n = 1'b0;
      #1;
      check("rr_cmd_ready", bus.cmd_ready, 1);
      check("rr_rsp_valid", bus.rsp_valid, 0);
      check("rr_busy_clr",  busy,          0);
      check("rr_count_clr", cmd_count,     0);
      check("rr_m_regs",    {bus.m_start, bus.m_write, bus.m_address, bus.m_write_data}, 0);
      repeat (2) @(negedge clock);
      reset_n  = 1'b1;
      busy_len = 3;
      repeat (40) @(negedge clock);
      check("rr_no_rsp",    bus.rsp_valid,  0);
      check("rr_no_issue",  start_cnt - s0, 1);
      check("rr_idle",      busy,           0);
      push_cmd(1'b1, 7'h51, 8'h56);
      get_rsp("rr_w51", 1'b1, 7'h51, 8'h56, 1'b0, 1'b0);
      check("rr_mock_addr",  mock_addr,  7'h51);
      check("rr_mock_wdata", mock_wdata, 8'h56);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
